// File: rtl/shared_dp_ram_be.sv
// Shared dual-port RAM with per-port request/valid handshake, byte enables,
// write-first reads, byte-merged same-address writes and collision tracking.
module shared_dp_ram_be #(
    parameter int LOCAL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int RD_PIPE          = 0,
    parameter int PRIO_MODE        = 0,
    parameter int COLL_CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_a,
    input  logic                        we_a,
    input  logic [DATA_WIDTH/8-1:0]     be_a,
    input  logic [LOCAL_ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]       wdata_a,
    output logic                        rvalid_a,
    output logic [DATA_WIDTH-1:0]       rdata_a,
    input  logic                        req_b,
    input  logic                        we_b,
    input  logic [DATA_WIDTH/8-1:0]     be_b,
    input  logic [LOCAL_ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]       wdata_b,
    output logic                        rvalid_b,
    output logic [DATA_WIDTH-1:0]       rdata_b,
    output logic                        coll_pulse,
    output logic [COLL_CNT_WIDTH-1:0]   coll_count
);
    // Handshake: a request is accepted in every cycle req_x is high; its rvalid_x
    // pulses exactly 1 (RD_PIPE=0) or 2 (RD_PIPE=1) cycles later, never stalls.
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << LOCAL_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_a, wr_b, same_addr, coll, a_wins, rr_b;
    logic [DATA_WIDTH-1:0] word_a, word_b;
    logic                  rv1_a, rv1_b;
    logic [DATA_WIDTH-1:0] rd1_a, rd1_b;

    // Resolves one stored word from up to two writers hitting its address.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic                  hit_a,
        input logic                  hit_b,
        input logic [NB-1:0]         bea,
        input logic [DATA_WIDTH-1:0] da,
        input logic [NB-1:0]         beb,
        input logic [DATA_WIDTH-1:0] db,
        input logic                  a_first
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (hit_a && bea[i] && (!(hit_b && beb[i]) || a_first))
                res[8*i +: 8] = da[8*i +: 8];
            else if (hit_b && beb[i])
                res[8*i +: 8] = db[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        wr_a      = req_a & we_a;
        wr_b      = req_b & we_b;
        same_addr = (addr_a == addr_b);
        coll      = wr_a & wr_b & same_addr & (|(be_a & be_b));
        case (PRIO_MODE)
            0:       a_wins = 1'b1;
            1:       a_wins = 1'b0;
            default: a_wins = ~rr_b;
        endcase
        word_a = merge_word(mem[addr_a], wr_a, wr_b & same_addr,
                            be_a, wdata_a, be_b, wdata_b, a_wins);
        word_b = merge_word(mem[addr_b], wr_a & same_addr, wr_b,
                            be_a, wdata_a, be_b, wdata_b, a_wins);
    end

    // Contents are not reset; the reset term only blocks commits while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n) begin
            if (wr_a) mem[addr_a] <= word_a;
            if (wr_b) mem[addr_b] <= word_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_a      <= 1'b0;
            rv1_b      <= 1'b0;
            rd1_a      <= '0;
            rd1_b      <= '0;
            coll_pulse <= 1'b0;
            coll_count <= '0;
            rr_b       <= 1'b0;
        end else begin
            rv1_a      <= req_a;
            rv1_b      <= req_b;
            if (req_a) rd1_a <= word_a;
            if (req_b) rd1_b <= word_b;
            coll_pulse <= coll;
            if (coll && (coll_count != {COLL_CNT_WIDTH{1'b1}}))
                coll_count <= coll_count + COLL_CNT_WIDTH'(1);
            // Pointer advances after being used for this cycle's collision.
            if (coll) rr_b <= ~rr_b;
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic                  rv2_a, rv2_b;
            logic [DATA_WIDTH-1:0] rd2_a, rd2_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rv2_a <= 1'b0;
                    rv2_b <= 1'b0;
                    rd2_a <= '0;
                    rd2_b <= '0;
                end else begin
                    rv2_a <= rv1_a;
                    rv2_b <= rv1_b;
                    if (rv1_a) rd2_a <= rd1_a;
                    if (rv1_b) rd2_b <= rd1_b;
                end
            end
            assign rvalid_a = rv2_a;
            assign rvalid_b = rv2_b;
            assign rdata_a  = rd2_a;
            assign rdata_b  = rd2_b;
        end else begin : g_nopipe
            assign rvalid_a = rv1_a;
            assign rvalid_b = rv1_b;
            assign rdata_a  = rd1_a;
            assign rdata_b  = rd1_b;
        end
    endgenerate
endmodule

// File: tb/tb_shared_dp_ram_be.sv
// Bench for shared_dp_ram_be: four configurations (A-prio, B-prio, round-robin
// with 2-bit counter, pipelined) share one stimulus stream and one reference model.
module tb_shared_dp_ram_be;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int ND = 4;
    localparam int PRIO_T [ND] = '{0, 1, 2, 0};
    localparam int PIPE_T [ND] = '{0, 0, 0, 1};
    localparam int CMAX_T [ND] = '{65535, 65535, 3, 65535};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, we_a, req_b, we_b;
    logic [3:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;

    logic          rva [ND];
    logic          rvb [ND];
    logic          cp  [ND];
    logic [DW-1:0] rda [ND];
    logic [DW-1:0] rdb [ND];
    logic [15:0]   cc0, cc1, cc3;
    logic [1:0]    cc2;
    logic [15:0]   cc_all [ND];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] mem_m [ND][1<<AW];
    logic          m_rva [ND];
    logic          m_rvb [ND];
    logic          m_cp  [ND];
    logic [DW-1:0] m_rda [ND];
    logic [DW-1:0] m_rdb [ND];
    int            m_cc  [ND];
    logic          rr_m  [ND];
    logic          p_va  [ND];
    logic          p_vb  [ND];
    logic [DW-1:0] p_da  [ND];
    logic [DW-1:0] p_db  [ND];

    always #5 clk = ~clk;

    assign cc_all[0] = cc0;
    assign cc_all[1] = cc1;
    assign cc_all[2] = {14'b0, cc2};
    assign cc_all[3] = cc3;

    shared_dp_ram_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PIPE(0), .PRIO_MODE(0), .COLL_CNT_WIDTH(16)) dut_prio_a (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a), .rvalid_a(rva[0]), .rdata_a(rda[0]),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b), .rvalid_b(rvb[0]), .rdata_b(rdb[0]),
        .coll_pulse(cp[0]), .coll_count(cc0));
    shared_dp_ram_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PIPE(0), .PRIO_MODE(1), .COLL_CNT_WIDTH(16)) dut_prio_b (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a), .rvalid_a(rva[1]), .rdata_a(rda[1]),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b), .rvalid_b(rvb[1]), .rdata_b(rdb[1]),
        .coll_pulse(cp[1]), .coll_count(cc1));
    shared_dp_ram_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PIPE(0), .PRIO_MODE(2), .COLL_CNT_WIDTH(2)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a), .rvalid_a(rva[2]), .rdata_a(rda[2]),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b), .rvalid_b(rvb[2]), .rdata_b(rdb[2]),
        .coll_pulse(cp[2]), .coll_count(cc2));
    shared_dp_ram_be #(.LOCAL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PIPE(1), .PRIO_MODE(0), .COLL_CNT_WIDTH(16)) dut_pipe (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a), .rvalid_a(rva[3]), .rdata_a(rda[3]),
        .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b), .rvalid_b(rvb[3]), .rdata_b(rdb[3]),
        .coll_pulse(cp[3]), .coll_count(cc3));

    function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old, input logic [DW-1:0] data, input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_rva[d] = 0; m_rvb[d] = 0; m_cp[d] = 0; m_rda[d] = '0; m_rdb[d] = '0;
            m_cc[d] = 0; rr_m[d] = 0; p_va[d] = 0; p_vb[d] = 0; p_da[d] = '0; p_db[d] = '0;
        end
    endtask

    // One clock edge of the reference: writers applied loser-first so the winner lands on top.
    task automatic model_update();
        logic wa, wb, coll, a_wins;
        logic [DW-1:0] ea, eb;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wa = req_a && we_a;
        wb = req_b && we_b;
        coll = wa && wb && (addr_a == addr_b) && ((be_a & be_b) != 4'b0);
        for (int d = 0; d < ND; d++) begin
            a_wins = (PRIO_T[d] == 0) || (PRIO_T[d] == 2 && !rr_m[d]);
            if (a_wins) begin
                if (wb) mem_m[d][addr_b] = apply_be(mem_m[d][addr_b], wdata_b, be_b);
                if (wa) mem_m[d][addr_a] = apply_be(mem_m[d][addr_a], wdata_a, be_a);
            end else begin
                if (wa) mem_m[d][addr_a] = apply_be(mem_m[d][addr_a], wdata_a, be_a);
                if (wb) mem_m[d][addr_b] = apply_be(mem_m[d][addr_b], wdata_b, be_b);
            end
            ea = mem_m[d][addr_a];
            eb = mem_m[d][addr_b];
            if (PIPE_T[d] != 0) begin
                m_rva[d] = p_va[d]; if (p_va[d]) m_rda[d] = p_da[d];
                m_rvb[d] = p_vb[d]; if (p_vb[d]) m_rdb[d] = p_db[d];
                p_va[d] = req_a; if (req_a) p_da[d] = ea;
                p_vb[d] = req_b; if (req_b) p_db[d] = eb;
            end else begin
                m_rva[d] = req_a; if (req_a) m_rda[d] = ea;
                m_rvb[d] = req_b; if (req_b) m_rdb[d] = eb;
            end
            m_cp[d] = coll;
            if (coll) begin
                if (m_cc[d] < CMAX_T[d]) m_cc[d]++;
                if (PRIO_T[d] == 2) rr_m[d] = !rr_m[d];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [3:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        req_a = r; we_a = w; be_a = be; addr_a = ad; wdata_a = dt;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [3:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        req_b = r; we_b = w; be_b = be; addr_b = ad; wdata_b = dt;
    endtask

    task automatic idle();
        drive_a(0, 0, 4'h0, '0, '0);
        drive_b(0, 0, 4'h0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({rva[d], rvb[d], cp[d]} !== 3'b0 || rda[d] !== '0 || rdb[d] !== '0 || cc_all[d] !== 16'd0) begin
                errors++;
                $display("FAIL reset dut%0d got rv=%b%b cp=%b rd=%h/%h cc=%0d want all zero",
                         d, rva[d], rvb[d], cp[d], rda[d], rdb[d], cc_all[d]);
            end
        end
        rst_n = 1'b1;
        // preload every word so no read ever sees uninitialised storage
        for (int i = 0; i < (1 << AW) / 2; i++) begin
            drive_a(1, 1, 4'hF, AW'(2 * i), $urandom);
            drive_b(1, 1, 4'hF, AW'(2 * i + 1), $urandom);
            step();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({rva[d], rda[d], rvb[d], rdb[d], cp[d], cc_all[d]} !==
                    {m_rva[d], m_rda[d], m_rvb[d], m_rdb[d], m_cp[d], 16'(m_cc[d])}) begin
                    errors++;
                    $display("FAIL preload dut%0d got %b %h %b %h %b %0d want %b %h %b %h %b %0d", d,
                             rva[d], rda[d], rvb[d], rdb[d], cp[d], cc_all[d],
                             m_rva[d], m_rda[d], m_rvb[d], m_rdb[d], m_cp[d], m_cc[d]);
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] want;
        for (int k = 0; k < 5; k++) begin
            drive_a(1, 1, 4'hF, 8'h70, 32'd1);
            drive_b(1, 1, 4'hF, 8'h70, 32'd2);
            step();
            want = (k % 2 == 0) ? 32'd1 : 32'd2;
            checks++;
            if (rda[2] !== want || rdb[2] !== want || cp[2] !== 1'b1) begin
                errors++;
                $display("FAIL rr_collision%0d got a=%h b=%h pulse=%b want %h pulse=1", k, rda[2], rdb[2], cp[2], want);
            end
            if (k == 2) begin
                checks++;
                if (cc_all[2] !== 16'd3 || cc_all[0] !== 16'd3) begin
                    errors++;
                    $display("FAIL rr_count3 got rr=%0d prio_a=%0d want 3 3", cc_all[2], cc_all[0]);
                end
            end
        end
        checks++;
        if (cc_all[2] !== 16'd3 || cc_all[0] !== 16'd5) begin
            errors++;
            $display("FAIL count_saturate got rr=%0d prio_a=%0d want 3 5", cc_all[2], cc_all[0]);
        end
        idle();
        step();
        checks++;
        if (cp[2] !== 1'b0 || cc_all[2] !== 16'd3) begin
            errors++;
            $display("FAIL rr_idle got pulse=%b cc=%0d want 0 3", cp[2], cc_all[2]);
        end
    endtask

    task automatic test_write_read();
        drive_a(1, 1, 4'hF, 8'h3F, 32'hDEADBEEF);
        step();
        idle();
        drive_b(1, 0, 4'h0, 8'h3F, '0);
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rvb[d] !== 1'b1 || rdb[d] !== 32'hDEADBEEF || rva[d] !== 1'b0) begin
                errors++;
                $display("FAIL write_read dut%0d got rvb=%b rdb=%h rva=%b want 1 deadbeef 0", d, rvb[d], rdb[d], rva[d]);
            end
        end
        // same-cycle write-first read on the other port
        drive_a(1, 1, 4'hF, 8'h40, 32'hA5A50001);
        drive_b(1, 0, 4'h0, 8'h40, '0);
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdb[d] !== 32'hA5A50001 || rda[d] !== 32'hA5A50001 || cp[d] !== 1'b0) begin
                errors++;
                $display("FAIL write_first dut%0d got b=%h a=%h cp=%b want a5a50001", d, rdb[d], rda[d], cp[d]);
            end
        end
        idle();
        step();
    endtask

    task automatic test_collision();
        drive_a(1, 1, 4'hF, 8'h55, 32'hAAAA5555);
        drive_b(1, 1, 4'hF, 8'h55, 32'hBBBBCCCC);
        step();
        checks++;
        if (rda[0] !== 32'hAAAA5555 || rdb[0] !== 32'hAAAA5555 || cp[0] !== 1'b1 || cc_all[0] !== 16'd6) begin
            errors++;
            $display("FAIL coll_prio_a got a=%h b=%h cp=%b cc=%0d want aaaa5555 1 6", rda[0], rdb[0], cp[0], cc_all[0]);
        end
        checks++;
        if (rda[1] !== 32'hBBBBCCCC || rdb[1] !== 32'hBBBBCCCC || cp[1] !== 1'b1) begin
            errors++;
            $display("FAIL coll_prio_b got a=%h b=%h cp=%b want bbbbcccc 1", rda[1], rdb[1], cp[1]);
        end
        drive_a(1, 0, 4'h0, 8'h55, '0);
        drive_b(1, 0, 4'h0, 8'h55, '0);
        step();
        checks++;
        if (rda[0] !== 32'hAAAA5555 || rdb[1] !== 32'hBBBBCCCC || cp[0] !== 1'b0) begin
            errors++;
            $display("FAIL coll_readback got prio_a=%h prio_b=%h cp=%b want aaaa5555 bbbbcccc 0", rda[0], rdb[1], cp[0]);
        end
        idle();
        step();
    endtask

    task automatic test_byte_merge();
        drive_a(1, 1, 4'hF, 8'h60, 32'h0);
        step();
        drive_a(1, 1, 4'b0011, 8'h60, 32'h11112222);
        drive_b(1, 1, 4'b1100, 8'h60, 32'h33334444);
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rda[d] !== 32'h33332222 || rdb[d] !== 32'h33332222 || cp[d] !== 1'b0) begin
                errors++;
                $display("FAIL byte_merge dut%0d got a=%h b=%h cp=%b want 33332222 0", d, rda[d], rdb[d], cp[d]);
            end
        end
        // be=0 write leaves the word alone but still answers
        drive_a(1, 1, 4'h0, 8'h60, 32'hFFFFFFFF);
        drive_b(0, 0, 4'h0, '0, '0);
        step();
        checks++;
        if (rva[0] !== 1'b1 || rda[0] !== 32'h33332222) begin
            errors++;
            $display("FAIL be_zero_write got rv=%b d=%h want 1 33332222", rva[0], rda[0]);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(8'h70, 8'h73)), $urandom);
            drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(8'h70, 8'h73)), $urandom);
            step();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({rva[d], rda[d], rvb[d], rdb[d], cp[d], cc_all[d]} !==
                    {m_rva[d], m_rda[d], m_rvb[d], m_rdb[d], m_cp[d], 16'(m_cc[d])}) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d got %b %h %b %h %b %0d want %b %h %b %h %b %0d", d, n,
                             rva[d], rda[d], rvb[d], rdb[d], cp[d], cc_all[d],
                             m_rva[d], m_rda[d], m_rvb[d], m_rdb[d], m_cp[d], m_cc[d]);
                end
            end
        end
        idle();
        repeat (2) step();
    endtask

    task automatic test_pipe_reset();
        drive_a(1, 1, 4'hF, 8'h0A, 32'hCAFEF00D);
        step();
        idle();
        repeat (2) step();
        drive_a(1, 0, 4'h0, 8'h0A, '0);
        step();
        checks++;
        if (rva[3] !== 1'b0 || rva[0] !== 1'b1 || rda[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pipe_lat1 got pipe_rv=%b flat_rv=%b flat_d=%h want 0 1 cafef00d", rva[3], rva[0], rda[0]);
        end
        step();
        checks++;
        if (rva[3] !== 1'b1 || rda[3] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pipe_lat2 got rv=%b d=%h want 1 cafef00d", rva[3], rda[3]);
        end
        // asynchronous reset with reads in flight in both pipeline stages
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({rva[d], rvb[d], cp[d]} !== 3'b0 || rda[d] !== '0 || rdb[d] !== '0 || cc_all[d] !== 16'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d got rv=%b%b cp=%b rd=%h/%h cc=%0d want all zero",
                         d, rva[d], rvb[d], cp[d], rda[d], rdb[d], cc_all[d]);
            end
        end
        drive_a(1, 1, 4'hF, 8'h0A, 32'h12345678);
        repeat (2) step();
        idle();
        rst_n = 1'b1;
        step();
        checks++;
        if (rva[3] !== 1'b0 || rda[3] !== '0) begin
            errors++;
            $display("FAIL dropped_inflight got rv=%b d=%h want 0 0", rva[3], rda[3]);
        end
        drive_a(1, 0, 4'h0, 8'h0A, '0);
        step();
        idle();
        checks++;
        if (rda[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL write_in_reset got %h want cafef00d", rda[0]);
        end
        step();
        checks++;
        if (rva[3] !== 1'b1 || rda[3] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL pipe_after_reset got rv=%b d=%h want 1 cafef00d", rva[3], rda[3]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_write_read();
        test_collision();
        test_byte_merge();
        test_random();
        test_pipe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
